csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Machine-mode CSR file and trap sequencer for the core. Owns the implemented machine CSRs (mstatus, mtvec, mepc, mcause, mtval, mcycle, read-only ID registers). Serves single-cycle CSR instruction accesses, and sequences exception entry and mret return as a PC redirect to fetch through a valid/ready handshake. Sits between the execute stage (requests) and the fetch PC mux (redirect).

## Interface
- XLEN, pkg_parameters::XLEN (32): data width.
- HART_ID, 0: value returned by mhartid.
- MISA_VALUE, 'h4000_0100: constant misa value (RV32I).
- RESET_MTVEC, 'h0000_0100: mtvec reset value.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous, active-low.
- exc_valid  in  1  exception request from execute.
- exc_code  in  XLEN  cause, pkg_csr::exception_code_e.
- exc_pc  in  XLEN  PC of the faulting instruction.
- exc_tval  in  XLEN  trap value.
- mret_valid  in  1  mret retiring.
- ctrl_ready  out  1  exception/mret accepted this cycle when high.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  XLEN  redirect target.
- redirect_ready  in  1  fetch consumed the redirect.
- csr_req  in  1  CSR instruction access.
- csr_addr  in  12  CSR address.
- csr_op  in  2  csr_op_e: RW, RS, RC, RD (read-only).
- csr_wdata  in  XLEN  rs1 value or zero-extended zimm.
- csr_gnt  out  1  access performed this cycle.
- csr_rdata  out  XLEN  old CSR value, combinational.
- csr_illegal  out  1  access is illegal; qualifies csr_gnt.

## Operation
- FSM states: IDLE, REDIRECT.
- ctrl_ready = (state==IDLE).
- Exception accepted (IDLE && exc_valid):
  - mepc <= exc_pc & ~3; mcause <= exc_code; mtval <= exc_tval.
  - mstatus.MPIE <= MIE; MIE <= 0.
  - redirect_pc <= mtvec & ~3 (direct mode only); state -> REDIRECT.
- mret accepted (IDLE && mret_valid && !exc_valid):
  - MIE <= MPIE; MPIE <= 1; redirect_pc <= mepc; state -> REDIRECT.
- REDIRECT: redirect_valid=1 and redirect_pc held stable until redirect_ready; on handshake, state -> IDLE.
- Simultaneous exc_valid and mret_valid: exception wins; the mret is dropped (the pipeline flushes it).
- csr_gnt = IDLE && csr_req && !exc_valid && !mret_valid. Trap sequencing always beats CSR instructions.
- Write value on a granted, legal access:
  - RW: wdata. RS: old | wdata. RC: old & ~wdata. RD: no write.
- mstatus fields:
  - Implemented: MIE[3], MPIE[7].
  - MPP[12:11] hardwired 2'b11.
  - All other bits read 0; writes to them are ignored.
- WARL fields: mtvec[1:0] and mepc[1:0] read 0. mcause and mtval store the full value.
- mcycle: +1 every cycle, wraps 2^XLEN-1 -> 0. A granted write loads the written value with no increment that cycle.
- Read-only CSRs:
  - mvendorid, marchid, mimpid, mconfigptr read 0; mhartid = HART_ID; misa = MISA_VALUE.
  - misa writes are ignored (legal).
- csr_illegal=1 when:
  - the address is unimplemented, or
  - addr[11:10]==2'b11 and op != RD.
  - Illegal accesses write nothing.

## Timing
- Reset values:
  - state=IDLE, redirect_valid=0, redirect_pc=0.
  - MIE=0, MPIE=0; mtvec=RESET_MTVEC.
  - mepc, mcause, mtval, mcycle = 0.
- csr_rdata, csr_gnt, csr_illegal: combinational, same cycle as csr_req. Writes commit at the next edge.
- Exception accepted in cycle N:
  - CSRs updated at the end of N.
  - redirect_valid=1 from N+1; minimum occupancy 2 cycles.
- A CSR read in N+1 returns the updated mepc/mcause.
- A new trap or CSR access is blocked while in REDIRECT.
- Reset asserted mid-REDIRECT: next cycle IDLE, redirect_valid=0, all CSRs at reset values.

## Structure
- Add to pkg_csr:
  - csr_op_e.
  - csr_trap_state_e.
  - mstatus bit positions MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7.
  - Reuse the existing CSR address constants and exception_code_e.
- Sub-module csr_cycle_counter: XLEN counter with load enable and load value. Everything else is flat.

## Test plan
- Reset, then read mtvec, mhartid, misa -> 'h100, 0, 'h4000_0100; mcycle increments each cycle.
- exc_valid with ILLEGAL_INSTRUCTION, exc_pc='h0000_0204, tval='hDEAD_BEEF, and MIE=1:
  - redirect_valid from the next cycle with redirect_pc='h100.
  - mepc='h204, mcause=2, mtval='hDEADBEEF, MIE=0, MPIE=1.
- Hold redirect_ready=0 for 3 cycles, then 1:
  - redirect_pc stable throughout; csr_gnt=0 throughout; IDLE after the handshake.
- mret after the trap -> redirect_pc='h204, MIE=1, MPIE=1.
- exc_valid, mret_valid and csr_req (RW mtvec) in the same cycle:
  - exception taken; mtvec unchanged; csr_gnt=0.
- Illegal and boundary accesses:
  - RW to mhartid -> csr_illegal=1, no write.
  - RS to 'h7C0 -> csr_illegal=1.
  - Write mcycle='hFFFF_FFFF -> reads 0 two cycles later.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode CSR file and trap sequencer.
// Holds the CSR address map, exception causes, CSR op encoding and FSM states.
package csr_trap_ctrl_pkg;

   localparam int XLEN = 32;

   localparam logic [11:0] CSR_MSTATUS    = 12'h300;
   localparam logic [11:0] CSR_MISA       = 12'h301;
   localparam logic [11:0] CSR_MTVEC      = 12'h305;
   localparam logic [11:0] CSR_MEPC       = 12'h341;
   localparam logic [11:0] CSR_MCAUSE     = 12'h342;
   localparam logic [11:0] CSR_MTVAL      = 12'h343;
   localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
   localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
   localparam logic [11:0] CSR_MARCHID    = 12'hF12;
   localparam logic [11:0] CSR_MIMPID     = 12'hF13;
   localparam logic [11:0] CSR_MHARTID    = 12'hF14;
   localparam logic [11:0] CSR_MCONFIGPTR = 12'hF15;

   typedef enum logic [31:0] {
      EXC_INSTR_MISALIGNED    = 32'd0,
      EXC_INSTR_FAULT         = 32'd1,
      EXC_ILLEGAL_INSTRUCTION = 32'd2,
      EXC_BREAKPOINT          = 32'd3,
      EXC_LOAD_MISALIGNED     = 32'd4,
      EXC_LOAD_FAULT          = 32'd5,
      EXC_STORE_MISALIGNED    = 32'd6,
      EXC_STORE_FAULT         = 32'd7,
      EXC_ECALL_M             = 32'd11
   } exception_code_e;

   typedef enum logic [1:0] {
      CSR_RW = 2'b00,
      CSR_RS = 2'b01,
      CSR_RC = 2'b10,
      CSR_RD = 2'b11
   } csr_op_e;

   typedef enum logic {
      TRAP_IDLE     = 1'b0,
      TRAP_REDIRECT = 1'b1
   } csr_trap_state_e;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/csr_trap_ctrl_cycle_counter.sv
// Free-running cycle counter with a synchronous load that replaces the increment.
module csr_cycle_counter
   import csr_trap_ctrl_pkg::*;
#(
   parameter int XLEN = csr_trap_ctrl_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_en,
   input  logic [XLEN-1:0] load_value,
   output logic [XLEN-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load_en)
         count <= load_value;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file plus trap entry / mret sequencer that redirects fetch.
// Trap sequencing always has priority over CSR instruction accesses.
module csr_trap_ctrl
   import csr_trap_ctrl_pkg::*;
#(
   parameter int              XLEN        = csr_trap_ctrl_pkg::XLEN,
   parameter logic [XLEN-1:0] HART_ID     = '0,
   parameter logic [XLEN-1:0] MISA_VALUE  = 'h4000_0100,
   parameter logic [XLEN-1:0] RESET_MTVEC = 'h0000_0100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            exc_valid,
   input  logic [XLEN-1:0] exc_code,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret_valid,
   output logic            ctrl_ready,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
   input  logic            csr_req,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_op,
   input  logic [XLEN-1:0] csr_wdata,
   output logic            csr_gnt,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal
);

   csr_trap_state_e state;
   csr_op_e         op;
   logic            idle;
   logic            exc_take;
   logic            mret_take;
   logic            mie;
   logic            mpie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;
   logic [XLEN-1:0] mtval;
   logic [XLEN-1:0] mcycle;
   logic [XLEN-1:0] mstatus;
   logic [XLEN-1:0] wval;
   logic            addr_known;
   logic            write_en;

   assign op         = csr_op_e'(csr_op);
   assign idle       = (state == TRAP_IDLE);
   assign exc_take   = idle && exc_valid;
   assign mret_take  = idle && mret_valid && !exc_valid;
   assign ctrl_ready = idle;
   assign csr_gnt    = idle && csr_req && !exc_valid && !mret_valid;

   // mstatus is assembled from the two live bits; MPP reads as machine mode.
   always_comb begin
      mstatus                   = '0;
      mstatus[12:11]            = 2'b11;
      mstatus[MSTATUS_MIE_BIT]  = mie;
      mstatus[MSTATUS_MPIE_BIT] = mpie;
   end

   always_comb begin
      csr_rdata  = '0;
      addr_known = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:    csr_rdata = mstatus;
         CSR_MISA:       csr_rdata = MISA_VALUE;
         CSR_MTVEC:      csr_rdata = mtvec;
         CSR_MEPC:       csr_rdata = mepc;
         CSR_MCAUSE:     csr_rdata = mcause;
         CSR_MTVAL:      csr_rdata = mtval;
         CSR_MCYCLE:     csr_rdata = mcycle;
         CSR_MVENDORID:  csr_rdata = '0;
         CSR_MARCHID:    csr_rdata = '0;
         CSR_MIMPID:     csr_rdata = '0;
         CSR_MHARTID:    csr_rdata = HART_ID;
         CSR_MCONFIGPTR: csr_rdata = '0;
         default:        addr_known = 1'b0;
      endcase
   end

   assign csr_illegal = csr_req &&
                        (!addr_known || ((csr_addr[11:10] == 2'b11) && (op != CSR_RD)));
   assign write_en    = csr_gnt && !csr_illegal && (op != CSR_RD);

   always_comb begin
      wval = csr_rdata;
      case (op)
         CSR_RW:  wval = csr_wdata;
         CSR_RS:  wval = csr_rdata | csr_wdata;
         CSR_RC:  wval = csr_rdata & ~csr_wdata;
         default: wval = csr_rdata;
      endcase
   end

   // Trap FSM; redirect_pc is captured on acceptance and held until fetch takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= TRAP_IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         case (state)
            TRAP_IDLE: begin
               if (exc_take) begin
                  redirect_pc    <= {mtvec[XLEN-1:2], 2'b00};
                  redirect_valid <= 1'b1;
                  state          <= TRAP_REDIRECT;
               end else if (mret_take) begin
                  redirect_pc    <= mepc;
                  redirect_valid <= 1'b1;
                  state          <= TRAP_REDIRECT;
               end
            end
            TRAP_REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  state          <= TRAP_IDLE;
               end
            end
            default: begin
               redirect_valid <= 1'b0;
               state          <= TRAP_IDLE;
            end
         endcase
      end
   end

   // CSR writes and trap side effects never collide because csr_gnt excludes traps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mie    <= 1'b0;
         mpie   <= 1'b0;
         mtvec  <= {RESET_MTVEC[XLEN-1:2], 2'b00};
         mepc   <= '0;
         mcause <= '0;
         mtval  <= '0;
      end else if (exc_take) begin
         mepc   <= {exc_pc[XLEN-1:2], 2'b00};
         mcause <= exc_code;
         mtval  <= exc_tval;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_take) begin
         mie    <= mpie;
         mpie   <= 1'b1;
      end else if (write_en) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mie  <= wval[MSTATUS_MIE_BIT];
               mpie <= wval[MSTATUS_MPIE_BIT];
            end
            CSR_MTVEC:  mtvec  <= {wval[XLEN-1:2], 2'b00};
            CSR_MEPC:   mepc   <= {wval[XLEN-1:2], 2'b00};
            CSR_MCAUSE: mcause <= wval;
            CSR_MTVAL:  mtval  <= wval;
            default: ;
         endcase
      end
   end

   csr_cycle_counter #(
      .XLEN (XLEN)
   ) u_cycle_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en    (write_en && (csr_addr == CSR_MCYCLE)),
      .load_value (wval),
      .count      (mcycle)
   );

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed scoreboard bench for csr_trap_ctrl: expectations are queued as
// stimulus is applied and popped as the corresponding DUT output is sampled.
module tb_csr_trap_ctrl;
   import csr_trap_ctrl_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exc_valid = 1'b0;
   logic [31:0] exc_code = '0;
   logic [31:0] exc_pc = '0;
   logic [31:0] exc_tval = '0;
   logic        mret_valid = 1'b0;
   logic        ctrl_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready = 1'b0;
   logic        csr_req = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [1:0]  csr_op = '0;
   logic [31:0] csr_wdata = '0;
   logic        csr_gnt;
   logic [31:0] csr_rdata;
   logic        csr_illegal;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   csr_trap_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .exc_valid      (exc_valid),
      .exc_code       (exc_code),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .mret_valid     (mret_valid),
      .ctrl_ready     (ctrl_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .csr_req        (csr_req),
      .csr_addr       (csr_addr),
      .csr_op         (csr_op),
      .csr_wdata      (csr_wdata),
      .csr_gnt        (csr_gnt),
      .csr_rdata      (csr_rdata),
      .csr_illegal    (csr_illegal)
   );

   always #5 clk = ~clk;

   task automatic expectVal(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] observed);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_empty observed=%h expected=<none>", observed);
      end else begin
         e = sb.pop_front();
         assert (observed === e.value)
         else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
         end
      end
   endtask

   // Drives one CSR access mid-cycle, leaving combinational outputs ready to sample.
   task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] op,
                                input logic [31:0] wdata);
      @(negedge clk);
      csr_req   = 1'b1;
      csr_addr  = addr;
      csr_op    = op;
      csr_wdata = wdata;
      #1;
   endtask

   task automatic endCycle();
      @(posedge clk);
      #1;
      csr_req = 1'b0;
   endtask

   task automatic csrRead(input string tag, input logic [11:0] addr,
                          input logic [31:0] value);
      expectVal(tag, value);
      applyStimulus(addr, CSR_RD, '0);
      checkOutput(csr_rdata);
      endCycle();
   endtask

   task automatic handshake();
      @(negedge clk);
      redirect_ready = 1'b1;
      @(posedge clk);
      #1;
      redirect_ready = 1'b0;
      expectVal("redirect_valid_after_hs", 32'd0);
      checkOutput({31'd0, redirect_valid});
      expectVal("ctrl_ready_after_hs", 32'd1);
      checkOutput({31'd0, ctrl_ready});
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(posedge clk);
      #1;
      expectVal("reset_redirect_valid", 32'd0);
      checkOutput({31'd0, redirect_valid});
      expectVal("reset_redirect_pc", 32'd0);
      checkOutput(redirect_pc);
      expectVal("reset_ctrl_ready", 32'd1);
      checkOutput({31'd0, ctrl_ready});
      @(negedge clk);
      rst_n = 1'b1;

      csrRead("mcycle_first", CSR_MCYCLE, 32'd1);
      csrRead("mtvec_reset", CSR_MTVEC, 32'h0000_0100);
      csrRead("mhartid", CSR_MHARTID, 32'd0);
      csrRead("misa", CSR_MISA, 32'h4000_0100);
      csrRead("mepc_reset", CSR_MEPC, 32'd0);
      csrRead("mcause_reset", CSR_MCAUSE, 32'd0);
      csrRead("mcycle_later", CSR_MCYCLE, 32'd7);
      csrRead("mstatus_reset", CSR_MSTATUS, 32'h0000_1800);

      expectVal("set_mie_gnt", 32'd1);
      applyStimulus(CSR_MSTATUS, CSR_RS, 32'h0000_0008);
      checkOutput({31'd0, csr_gnt});
      endCycle();
      csrRead("mstatus_mie_set", CSR_MSTATUS, 32'h0000_1808);

      // Exception entry with a CSR request that must lose to the trap.
      @(negedge clk);
      exc_valid = 1'b1;
      exc_code  = EXC_ILLEGAL_INSTRUCTION;
      exc_pc    = 32'h0000_0204;
      exc_tval  = 32'hDEAD_BEEF;
      csr_req   = 1'b1;
      csr_addr  = CSR_MEPC;
      csr_op    = CSR_RD;
      #1;
      expectVal("exc_ctrl_ready", 32'd1);
      checkOutput({31'd0, ctrl_ready});
      expectVal("exc_cycle_gnt", 32'd0);
      checkOutput({31'd0, csr_gnt});
      expectVal("exc_redirect_valid", 32'd1);
      expectVal("exc_redirect_pc", 32'h0000_0100);
      @(posedge clk);
      #1;
      exc_valid = 1'b0;
      csr_req   = 1'b0;
      checkOutput({31'd0, redirect_valid});
      checkOutput(redirect_pc);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         csr_req  = 1'b1;
         csr_addr = CSR_MEPC;
         csr_op   = CSR_RD;
         #1;
         expectVal("hold_gnt", 32'd0);
         checkOutput({31'd0, csr_gnt});
         expectVal("hold_mepc_rdata", 32'h0000_0204);
         checkOutput(csr_rdata);
         expectVal("hold_redirect_valid", 32'd1);
         checkOutput({31'd0, redirect_valid});
         expectVal("hold_redirect_pc", 32'h0000_0100);
         checkOutput(redirect_pc);
      end
      @(negedge clk);
      csr_req = 1'b0;
      handshake();

      csrRead("trap_mepc", CSR_MEPC, 32'h0000_0204);
      csrRead("trap_mcause", CSR_MCAUSE, 32'd2);
      csrRead("trap_mtval", CSR_MTVAL, 32'hDEAD_BEEF);
      csrRead("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);

      // mret back to the faulting pc.
      @(negedge clk);
      mret_valid = 1'b1;
      #1;
      expectVal("mret_ctrl_ready", 32'd1);
      checkOutput({31'd0, ctrl_ready});
      expectVal("mret_redirect_valid", 32'd1);
      expectVal("mret_redirect_pc", 32'h0000_0204);
      @(posedge clk);
      #1;
      mret_valid = 1'b0;
      checkOutput({31'd0, redirect_valid});
      checkOutput(redirect_pc);
      handshake();
      csrRead("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

      // Exception, mret and a CSR write all in one cycle.
      @(negedge clk);
      exc_valid  = 1'b1;
      exc_code   = EXC_ECALL_M;
      exc_pc     = 32'h0000_0302;
      exc_tval   = 32'd0;
      mret_valid = 1'b1;
      csr_req    = 1'b1;
      csr_addr   = CSR_MTVEC;
      csr_op     = CSR_RW;
      csr_wdata  = 32'h0000_0400;
      #1;
      expectVal("collide_gnt", 32'd0);
      checkOutput({31'd0, csr_gnt});
      expectVal("collide_redirect_valid", 32'd1);
      expectVal("collide_redirect_pc", 32'h0000_0100);
      @(posedge clk);
      #1;
      exc_valid  = 1'b0;
      mret_valid = 1'b0;
      csr_req    = 1'b0;
      checkOutput({31'd0, redirect_valid});
      checkOutput(redirect_pc);
      handshake();
      csrRead("collide_mtvec", CSR_MTVEC, 32'h0000_0100);
      csrRead("collide_mepc", CSR_MEPC, 32'h0000_0300);
      csrRead("collide_mcause", CSR_MCAUSE, 32'd11);
      csrRead("collide_mstatus", CSR_MSTATUS, 32'h0000_1880);

      // Illegal and boundary accesses.
      expectVal("mhartid_rw_illegal", 32'd1);
      applyStimulus(CSR_MHARTID, CSR_RW, 32'd5);
      checkOutput({31'd0, csr_illegal});
      endCycle();
      csrRead("mhartid_after_rw", CSR_MHARTID, 32'd0);

      expectVal("rs_7c0_illegal", 32'd1);
      applyStimulus(12'h7C0, CSR_RS, 32'd1);
      checkOutput({31'd0, csr_illegal});
      endCycle();

      expectVal("mip_rd_illegal", 32'd1);
      applyStimulus(12'h344, CSR_RD, 32'd0);
      checkOutput({31'd0, csr_illegal});
      endCycle();

      expectVal("misa_rw_legal", 32'd0);
      applyStimulus(CSR_MISA, CSR_RW, 32'h1234_5678);
      checkOutput({31'd0, csr_illegal});
      endCycle();
      csrRead("misa_unchanged", CSR_MISA, 32'h4000_0100);

      applyStimulus(CSR_MTVEC, CSR_RW, 32'h0000_0203);
      endCycle();
      csrRead("mtvec_warl", CSR_MTVEC, 32'h0000_0200);

      applyStimulus(CSR_MEPC, CSR_RC, 32'h0000_0100);
      endCycle();
      csrRead("mepc_rc", CSR_MEPC, 32'h0000_0200);

      applyStimulus(CSR_MCYCLE, CSR_RW, 32'hFFFF_FFFF);
      endCycle();
      csrRead("mcycle_loaded", CSR_MCYCLE, 32'hFFFF_FFFF);
      csrRead("mcycle_wrapped", CSR_MCYCLE, 32'd0);

      // Reset while a redirect is outstanding.
      @(negedge clk);
      exc_valid = 1'b1;
      exc_code  = EXC_BREAKPOINT;
      exc_pc    = 32'h0000_0500;
      expectVal("pre_reset_redirect_pc", 32'h0000_0200);
      @(posedge clk);
      #1;
      exc_valid = 1'b0;
      checkOutput(redirect_pc);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      expectVal("midreset_redirect_valid", 32'd0);
      checkOutput({31'd0, redirect_valid});
      expectVal("midreset_ctrl_ready", 32'd1);
      checkOutput({31'd0, ctrl_ready});
      @(negedge clk);
      rst_n = 1'b1;
      csrRead("midreset_mtvec", CSR_MTVEC, 32'h0000_0100);
      csrRead("midreset_mepc", CSR_MEPC, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
